// File: rtl/uart_pkg.sv
// uart_pkg: receiver FSM states and parity helper shared by the UART blocks
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

   // Zero-extending the data to 9 bits leaves its XOR unchanged.
   function automatic logic parity_of(input logic [8:0] data, input logic even);
      return even ? ^data : ~^data;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two FIFO; a pop is applied before a push in the same cycle
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level,
   output logic [WIDTH-1:0]           head
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign full    = level == (AW+1)'(DEPTH);
   assign empty   = level == '0;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
         rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
         level  <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;

endmodule

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: UART receiver feeding a FIFO; define UART_RX_SYNC_EN for a 2-flop serial_i synchroniser
module uart_rx_buffered
   import uart_pkg::*;
#(
   parameter int DATA_BITS     = 8,
   parameter int FIFO_DEPTH    = 4,
   parameter int DIVIDER_WIDTH = 16
) (
   input  logic                          clock_i,
   input  logic                          reset_i,
   input  logic                          serial_i,
   input  logic [DIVIDER_WIDTH-1:0]      clock_divider_i,
   input  logic                          parity_bit_i,
   input  logic                          parity_even_i,
   input  logic                          ack_i,
   output logic [DATA_BITS-1:0]          data_o,
   output logic                          ready_o,
   output logic [$clog2(FIFO_DEPTH):0]   level_o,
   output logic                          frame_err_o,
   output logic                          parity_err_o,
   output logic                          overrun_o
);

   localparam logic [DIVIDER_WIDTH-1:0] ONE = DIVIDER_WIDTH'(1);
   localparam logic [DIVIDER_WIDTH-1:0] MIN_DIV = DIVIDER_WIDTH'(2);

   uart_state_t                state, state_n;
   logic [DIVIDER_WIDTH-1:0]   cnt, cnt_n, div, div_n, div_in;
   logic [3:0]                 bit_cnt, bit_n;
   logic [DATA_BITS-1:0]       sh, sh_n;
   logic                       par_en, par_en_n, par_even, par_even_n, par_bad, par_bad_n;
   logic                       ferr_n, perr_n, ovr_n, ack_q;
   logic                       s, expired, push, pop, full, empty;

`ifdef UART_RX_SYNC_EN
   logic [1:0] sync;
   always_ff @(posedge clock_i)
      sync <= !reset_i ? 2'b11 : {sync[0], serial_i};
   assign s = sync[1];
`else
   assign s = serial_i;
`endif

   assign div_in  = clock_divider_i < MIN_DIV ? MIN_DIV : clock_divider_i;
   assign expired = cnt == ONE;
   assign pop     = ack_i && !ack_q;
   assign ready_o = !empty;

   always_comb begin
      state_n    = state;
      cnt_n      = expired ? div : cnt - ONE;
      div_n      = div;
      bit_n      = bit_cnt;
      sh_n       = sh;
      par_en_n   = par_en;
      par_even_n = par_even;
      par_bad_n  = par_bad;
      push       = 1'b0;
      ferr_n     = 1'b0;
      perr_n     = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = cnt;
            if (!s) begin
               state_n    = START;
               div_n      = div_in;
               cnt_n      = div_in >> 1;
               bit_n      = '0;
               par_en_n   = parity_bit_i;
               par_even_n = parity_even_i;
               par_bad_n  = 1'b0;
            end
         end
         START:
            if (expired) state_n = s ? IDLE : DATA;
         DATA:
            if (expired) begin
               sh_n  = {s, sh[DATA_BITS-1:1]};
               bit_n = bit_cnt + 4'd1;
               if (bit_cnt == 4'(DATA_BITS - 1)) state_n = par_en ? PARITY : STOP;
            end
         PARITY:
            if (expired) begin
               par_bad_n = s != parity_of(9'(sh), par_even);
               perr_n    = par_bad_n;
               state_n   = STOP;
            end
         STOP:
            if (expired) begin
               state_n = IDLE;
               ferr_n  = !s;
               push    = s && !par_bad;
            end
         default: state_n = IDLE;
      endcase
      // A pop always frees a slot, so a same-cycle push into a full FIFO is not an overrun.
      ovr_n = (pop && !empty) ? 1'b0 : (push && full) ? 1'b1 : overrun_o;
   end

   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         state        <= IDLE;
         cnt          <= '0;
         div          <= MIN_DIV;
         bit_cnt      <= '0;
         sh           <= '0;
         par_en       <= 1'b0;
         par_even     <= 1'b0;
         par_bad      <= 1'b0;
         frame_err_o  <= 1'b0;
         parity_err_o <= 1'b0;
         overrun_o    <= 1'b0;
         ack_q        <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         div          <= div_n;
         bit_cnt      <= bit_n;
         sh           <= sh_n;
         par_en       <= par_en_n;
         par_even     <= par_even_n;
         par_bad      <= par_bad_n;
         frame_err_o  <= ferr_n;
         parity_err_o <= perr_n;
         overrun_o    <= ovr_n;
         ack_q        <= ack_i;
      end
   end

   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clock_i),
      .rst_n (reset_i),
      .push  (push),
      .pop   (pop),
      .din   (sh),
      .full  (full),
      .empty (empty),
      .level (level_o),
      .head  (data_o)
   );

endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb_uart_rx_buffered: directed checks of uart_rx_buffered at divider 2, 8 data bits, depth 4
module tb_uart_rx_buffered;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        serial = 1'b1;
   logic [15:0] divider = 16'd2;
   logic        par_on = 1'b0;
   logic        par_even = 1'b0;
   logic        ack = 1'b0;
   logic [7:0]  data;
   logic        ready, ferr, perr, ovr;
   logic [2:0]  level;
   int          pass_cnt = 0;
   int          total_cnt = 0;
   int          ferr_cnt = 0;
   int          perr_cnt = 0;

   always #5 clk = ~clk;

   uart_rx_buffered dut (
      .clock_i         (clk),
      .reset_i         (rst_n),
      .serial_i        (serial),
      .clock_divider_i (divider),
      .parity_bit_i    (par_on),
      .parity_even_i   (par_even),
      .ack_i           (ack),
      .data_o          (data),
      .ready_o         (ready),
      .level_o         (level),
      .frame_err_o     (ferr),
      .parity_err_o    (perr),
      .overrun_o       (ovr)
   );

   always @(negedge clk) begin
      if (ferr) ferr_cnt++;
      if (perr) perr_cnt++;
   end

   task automatic do_reset();
      rst_n = 1'b0; serial = 1'b1; ack = 1'b0; par_on = 1'b0; par_even = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic with_par, input logic par_val,
                             input logic stop_val, input logic pop_at_stop);
      serial = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         serial = d[i];
         repeat (2) @(negedge clk);
      end
      if (with_par) begin
         serial = par_val;
         repeat (2) @(negedge clk);
      end
      serial = stop_val;
      @(negedge clk);
      ack = pop_at_stop;
      @(negedge clk);
      ack = 1'b0;
      serial = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      total_cnt++; if ({data, ready, level, ferr, perr, ovr} !== 14'd0) $display("FAIL reset outputs got %h exp 0", {data, ready, level, ferr, perr, ovr}); else pass_cnt++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      int f0 = ferr_cnt, p0 = perr_cnt;
      do_reset();
      send_frame(8'h55, 0, 0, 1, 0);
      total_cnt++; if (ready !== 1'b1) $display("FAIL single ready got %b exp 1", ready); else pass_cnt++;
      total_cnt++; if (data !== 8'h55) $display("FAIL single data got %h exp 55", data); else pass_cnt++;
      total_cnt++; if (level !== 3'd1) $display("FAIL single level got %0d exp 1", level); else pass_cnt++;
      total_cnt++; if ({ferr_cnt - f0, perr_cnt - p0, ovr} !== {32'd0, 32'd0, 1'b0}) $display("FAIL single errors got %0d %0d %b exp 0 0 0", ferr_cnt - f0, perr_cnt - p0, ovr); else pass_cnt++;
   endtask

   task automatic test_ack_hold();
      do_reset();
      send_frame(8'h55, 0, 0, 1, 0);
      send_frame(8'hAA, 0, 0, 1, 0);
      ack = 1'b1;
      repeat (10) @(negedge clk);
      total_cnt++; if (data !== 8'hAA) $display("FAIL hold data got %h exp aa", data); else pass_cnt++;
      total_cnt++; if (level !== 3'd1) $display("FAIL hold level got %0d exp 1", level); else pass_cnt++;
      ack = 1'b0;
      @(negedge clk);
      pulse_ack();
      total_cnt++; if ({ready, level} !== 4'd0) $display("FAIL second pop got ready %b level %0d exp 0 0", ready, level); else pass_cnt++;
      pulse_ack();
      total_cnt++; if ({ready, level, data} !== 12'd0) $display("FAIL empty pop got ready %b level %0d data %h exp 0 0 0", ready, level, data); else pass_cnt++;
   endtask

   task automatic test_overrun();
      logic [7:0] exp_words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      do_reset();
      send_frame(8'h11, 0, 0, 1, 0);
      send_frame(8'h22, 0, 0, 1, 0);
      send_frame(8'h33, 0, 0, 1, 0);
      send_frame(8'h44, 0, 0, 1, 0);
      total_cnt++; if (ovr !== 1'b0) $display("FAIL overrun at full got %b exp 0", ovr); else pass_cnt++;
      send_frame(8'h55, 0, 0, 1, 0);
      total_cnt++; if (level !== 3'd4) $display("FAIL overrun level got %0d exp 4", level); else pass_cnt++;
      total_cnt++; if (ovr !== 1'b1) $display("FAIL overrun flag got %b exp 1", ovr); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         total_cnt++; if (data !== exp_words[i]) $display("FAIL overrun word %0d got %h exp %h", i, data, exp_words[i]); else pass_cnt++;
         pulse_ack();
         total_cnt++; if (ovr !== 1'b0) $display("FAIL overrun clear %0d got %b exp 0", i, ovr); else pass_cnt++;
      end
      total_cnt++; if (level !== 3'd0) $display("FAIL overrun drain level got %0d exp 0", level); else pass_cnt++;
   endtask

   task automatic test_push_pop_same_cycle();
      do_reset();
      send_frame(8'h11, 0, 0, 1, 0);
      send_frame(8'h22, 0, 0, 1, 0);
      send_frame(8'h33, 0, 0, 1, 0);
      send_frame(8'h44, 0, 0, 1, 0);
      send_frame(8'h55, 0, 0, 1, 1);
      total_cnt++; if (level !== 3'd4) $display("FAIL full push+pop level got %0d exp 4", level); else pass_cnt++;
      total_cnt++; if (ovr !== 1'b0) $display("FAIL full push+pop overrun got %b exp 0", ovr); else pass_cnt++;
      total_cnt++; if (data !== 8'h22) $display("FAIL full push+pop head got %h exp 22", data); else pass_cnt++;
      repeat (3) pulse_ack();
      total_cnt++; if (data !== 8'h55) $display("FAIL full push+pop tail got %h exp 55", data); else pass_cnt++;
      do_reset();
      send_frame(8'h66, 0, 0, 1, 1);
      total_cnt++; if ({level, data} !== {3'd1, 8'h66}) $display("FAIL empty push+pop got level %0d data %h exp 1 66", level, data); else pass_cnt++;
   endtask

   task automatic test_parity();
      int p0;
      do_reset();
      par_on = 1'b1; par_even = 1'b1;
      p0 = perr_cnt;
      send_frame(8'h07, 1, 1, 1, 0);
      total_cnt++; if ({level, data} !== {3'd1, 8'h07}) $display("FAIL parity good got level %0d data %h exp 1 07", level, data); else pass_cnt++;
      total_cnt++; if (perr_cnt !== p0) $display("FAIL parity good pulses got %0d exp %0d", perr_cnt, p0); else pass_cnt++;
      send_frame(8'h07, 1, 0, 1, 0);
      total_cnt++; if (perr_cnt !== p0 + 1) $display("FAIL parity bad pulses got %0d exp %0d", perr_cnt, p0 + 1); else pass_cnt++;
      total_cnt++; if (level !== 3'd1) $display("FAIL parity bad level got %0d exp 1", level); else pass_cnt++;
      par_even = 1'b0;
      send_frame(8'h07, 1, 0, 1, 0);
      total_cnt++; if (level !== 3'd2) $display("FAIL odd parity level got %0d exp 2", level); else pass_cnt++;
      par_on = 1'b0; par_even = 1'b0;
   endtask

   task automatic test_framing();
      int f0;
      do_reset();
      f0 = ferr_cnt;
      send_frame(8'hC3, 0, 0, 0, 0);
      total_cnt++; if (ferr_cnt !== f0 + 1) $display("FAIL frame err pulses got %0d exp %0d", ferr_cnt, f0 + 1); else pass_cnt++;
      total_cnt++; if (level !== 3'd0) $display("FAIL frame err level got %0d exp 0", level); else pass_cnt++;
      serial = 1'b0;
      @(negedge clk);
      serial = 1'b1;
      repeat (25) @(negedge clk);
      total_cnt++; if ({level, ferr_cnt} !== {3'd0, f0 + 1}) $display("FAIL glitch got level %0d ferr %0d exp 0 %0d", level, ferr_cnt, f0 + 1); else pass_cnt++;
      send_frame(8'h5A, 0, 0, 1, 0);
      total_cnt++; if ({level, data} !== {3'd1, 8'h5A}) $display("FAIL after glitch got level %0d data %h exp 1 5a", level, data); else pass_cnt++;
   endtask

   task automatic test_mid_frame_reset();
      do_reset();
      send_frame(8'h33, 0, 0, 1, 0);
      serial = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         serial = 1'b0;
         repeat (2) @(negedge clk);
      end
      rst_n = 1'b0;
      serial = 1'b1;
      repeat (2) @(negedge clk);
      total_cnt++; if ({data, ready, level, ferr, perr, ovr} !== 14'd0) $display("FAIL mid reset outputs got %h exp 0", {data, ready, level, ferr, perr, ovr}); else pass_cnt++;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      send_frame(8'h0F, 0, 0, 1, 0);
      total_cnt++; if ({level, data} !== {3'd1, 8'h0F}) $display("FAIL after reset got level %0d data %h exp 1 0f", level, data); else pass_cnt++;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single();
      test_ack_hold();
      test_overrun();
      test_push_pop_same_cycle();
      test_parity();
      test_framing();
      test_mid_frame_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
